// File: rtl/camera_downsampler_pkg.sv
// Shared constants and types for the camera capture path. The colour
// detection image processor imports the same package so both sides agree
// on screen geometry and on where the RGB332 fields sit.
package camera_downsampler_pkg;

  // Frame buffer geometry (QCIF)
  localparam int SCREEN_W = 176;
  localparam int SCREEN_H = 144;

  // Coordinate counters are 10 bits wide and saturate rather than wrap
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Capture state machine encoding
  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_VBLANK  = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // RGB332 field positions inside PIXEL_OUT
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // The image processor thresholds only the upper two bits of R and G
  localparam int R_THR_MSB = 7;
  localparam int R_THR_LSB = 6;
  localparam int G_THR_MSB = 4;
  localparam int G_THR_LSB = 3;

  // Increment that sticks at all-ones so oversize frames cannot wrap back
  // into the visible window
  function automatic coord_t coord_sat_inc(input coord_t v);
    return (v == '1) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/camera_downsampler_rgb565_to_rgb332.sv
// Pure combinational RGB565 -> RGB332 pack. The two bytes are given in
// arrival order; SWAP_BYTES says which of them carries the red field.
module camera_downsampler_rgb565_to_rgb332
  import camera_downsampler_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic [7:0] first_i,
  input  logic [7:0] second_i,
  output logic [7:0] pixel_o
);

  logic [7:0] hi;
  logic [7:0] lo;
  logic       unused_bits;

  // hi = RRRRRGGG, lo = GGGBBBBB; keep the top bits of R, the low G bits of
  // hi and the upper two blue bits of lo
  always_comb begin
    hi      = SWAP_BYTES ? second_i : first_i;
    lo      = SWAP_BYTES ? first_i : second_i;
    pixel_o = '0;
    pixel_o[R_MSB:R_LSB] = hi[7:5];
    pixel_o[G_MSB:G_LSB] = hi[2:0];
    pixel_o[B_MSB:B_LSB] = lo[4:3];
  end

  // Dropped colour LSBs are intentionally discarded
  assign unused_bits = ^{hi[4:3], lo[7:5], lo[2:0]};

endmodule

// File: rtl/camera_downsampler.sv
// OV7670 capture front end: samples the RGB565 byte stream, packs each
// pixel to RGB332 and issues frame-buffer writes with X/Y coordinates.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SYNC    | after reset; waiting for VSYNC high to drop any partial frame
// ST_VBLANK  | VSYNC high; counters are cleared when VSYNC falls
// ST_CAPTURE | active frame; bytes taken while HREF high, ends on VSYNC
module camera_downsampler
  import camera_downsampler_pkg::*;
#(
  parameter int WIDTH      = SCREEN_W,
  parameter int HEIGHT     = SCREEN_H,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CAM_DATA,
  input  logic       CAM_HREF,
  input  logic       CAM_VSYNC,
  output logic [7:0] PIXEL_OUT,
  output logic       W_EN,
  output logic [9:0] WRITE_X,
  output logic [9:0] WRITE_Y,
  output logic       FRAME_DONE,
  output logic       LINE_ERR
);

  localparam coord_t WIDTH_C  = coord_t'(WIDTH);
  localparam coord_t HEIGHT_C = coord_t'(HEIGHT);

  cap_state_e state_q;
  logic       phase_q;
  logic       href_q;
  logic [7:0] byte0_q;
  coord_t     x_q;
  coord_t     y_q;

  logic [7:0] pixel_q;
  logic       wen_q;
  coord_t     wx_q;
  coord_t     wy_q;
  logic       fdone_q;
  logic       lerr_q;

  logic [7:0] pixel_d;
  coord_t     x_inc_d;
  coord_t     y_inc_d;
  logic       in_window_d;
  logic       len_bad_d;

  camera_downsampler_rgb565_to_rgb332 #(
    .SWAP_BYTES(SWAP_BYTES)
  ) u_pack (
    .first_i (byte0_q),
    .second_i(CAM_DATA),
    .pixel_o (pixel_d)
  );

  // Counter increments and the write-window / line-length qualifiers
  always_comb begin
    x_inc_d     = coord_sat_inc(x_q);
    y_inc_d     = coord_sat_inc(y_q);
    in_window_d = (x_q < WIDTH_C) && (y_q < HEIGHT_C);
    len_bad_d   = (x_q != WIDTH_C) && (y_q < HEIGHT_C);
  end

  // Capture FSM with counters, byte phase and all registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_SYNC;
      phase_q <= 1'b0;
      href_q  <= 1'b0;
      byte0_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pixel_q <= '0;
      wen_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      fdone_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      href_q  <= CAM_HREF;
      wen_q   <= 1'b0;
      fdone_q <= 1'b0;
      unique case (state_q)
        ST_SYNC: begin
          if (CAM_VSYNC) begin
            state_q <= ST_VBLANK;
          end
        end
        ST_VBLANK: begin
          if (!CAM_VSYNC) begin
            state_q <= ST_CAPTURE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            lerr_q  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // VSYNC takes priority over any byte presented in the same cycle
          if (CAM_VSYNC) begin
            fdone_q <= 1'b1;
            state_q <= ST_VBLANK;
          end else if (CAM_HREF) begin
            if (!phase_q) begin
              byte0_q <= CAM_DATA;
              phase_q <= 1'b1;
            end else begin
              pixel_q <= pixel_d;
              wx_q    <= x_q;
              wy_q    <= y_q;
              wen_q   <= in_window_d;
              x_q     <= x_inc_d;
              phase_q <= 1'b0;
            end
          end else if (href_q) begin
            // End of line: a pending first byte is simply dropped
            x_q     <= '0;
            y_q     <= y_inc_d;
            phase_q <= 1'b0;
            if (phase_q || len_bad_d) begin
              lerr_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign W_EN       = wen_q;
  assign WRITE_X    = wx_q;
  assign WRITE_Y    = wy_q;
  assign FRAME_DONE = fdone_q;
  assign LINE_ERR   = lerr_q;

endmodule

// File: doc/camera_downsampler.md
# camera_downsampler

Capture front end for the camera path. Samples the OV7670 8-bit parallel bus in RGB565 mode (two bytes per pixel) and packs each pixel into one RGB332 byte. Produces a write strobe with X/Y coordinates for the frame buffer; the frame buffer feeds the VGA driver and the colour-detection image processor. Also reports frame boundaries so downstream logic can align per-frame work.

## Interface

Parameters:
- `WIDTH`, default 176: active pixels per line written to the buffer.
- `HEIGHT`, default 144: active lines per frame written to the buffer.
- `SWAP_BYTES`, default 0: 0 means the high RGB565 byte arrives first; 1 means the low byte arrives first.

Ports:
- `CLK` in, 1: camera pixel clock (PCLK). This is the only clock.
- `RESET` in, 1: synchronous, active-high reset.
- `CAM_DATA` in, 8: camera data bus D[7:0].
- `CAM_HREF` in, 1: high while line bytes are valid.
- `CAM_VSYNC` in, 1: high during vertical sync. The frame starts after it falls.
- `PIXEL_OUT` out, 8: RGB332 pixel as {R[2:0], G[2:0], B[1:0]}.
- `W_EN` out, 1: one-cycle frame-buffer write strobe.
- `WRITE_X` out, 10: column for `PIXEL_OUT`.
- `WRITE_Y` out, 10: row for `PIXEL_OUT`.
- `FRAME_DONE` out, 1: one-cycle pulse at end of a captured frame.
- `LINE_ERR` out, 1: sticky flag; cleared by `RESET` or at frame start.

## Operation

State machine `SYNC` → `VBLANK` → `CAPTURE`:

- **SYNC** (entered on reset)
  - Wait for `CAM_VSYNC` = 1, then go to `VBLANK`.
  - This discards any partial frame after reset.
- **VBLANK**
  - On `CAM_VSYNC` = 0, go to `CAPTURE`.
  - On that transition: clear the X counter, Y counter, byte phase and `LINE_ERR`.
- **CAPTURE**
  - While `CAM_HREF` = 1, each cycle latches one byte and the byte phase toggles.
  - Phase 0: store the first byte.
  - Phase 1: form the pixel and register it.
  - Packing with hi = high RGB565 byte (RRRRRGGG) and lo = low byte (GGGBBBBB): R = hi[7:5], G = hi[2:0], B = lo[4:3].
  - `SWAP_BYTES` = 1 selects which sampled byte is hi.
  - `W_EN` asserts only if X < `WIDTH` and Y < `HEIGHT`. X increments on every completed pixel and saturates at 1023.
  - Falling edge of `CAM_HREF` (registered HREF = 1, current = 0): clear X, increment Y (saturates at 1023), reset byte phase.
  - If phase was 1 at HREF fall (odd byte count), discard the dangling byte and set `LINE_ERR`.
  - If X at HREF fall is not equal to `WIDTH` ×(line length mismatch) and Y < `HEIGHT`, also set `LINE_ERR`.
  - `CAM_VSYNC` = 1 in `CAPTURE`: pulse `FRAME_DONE` for one cycle and go to `VBLANK`.
  - A partial line in progress is dropped: no `W_EN` for its dangling byte.
- `CAM_VSYNC` = 1 and `CAM_HREF` = 1 in the same cycle: VSYNC wins and the byte is ignored.
- `CAM_HREF` is ignored in `SYNC` and `VBLANK`.

## Timing

- All outputs are registered.
- Reset values: `PIXEL_OUT` = 0, `W_EN` = 0, `WRITE_X` = 0, `WRITE_Y` = 0, `FRAME_DONE` = 0, `LINE_ERR` = 0. State = `SYNC`.
- `RESET` asserted mid-frame: outputs return to reset values on the next edge. Capture resumes only after a full VSYNC high→low sequence.
- Latency: if the second byte of a pixel is sampled at edge N, then `W_EN`, `PIXEL_OUT`, `WRITE_X` and `WRITE_Y` are valid for exactly the cycle after edge N.
  - `WRITE_X`/`WRITE_Y` are the coordinates of that pixel, not the post-increment values.
- Writes occur at most every second cycle. Maximum writes per frame = `WIDTH` × `HEIGHT`.
- `FRAME_DONE` is high the cycle after the first `CAM_VSYNC` = 1 sample in `CAPTURE`.
- Edge detection uses a one-stage registered copy of HREF. No extra synchronizers: all inputs are PCLK-synchronous.

## Structure

- Shared package/include (`camera_defs`):
  - Screen constants 176/144.
  - State encodings `SYNC`/`VBLANK`/`CAPTURE`.
  - RGB332 field positions: R [7:6] upper used by the image processor, G [4:3], B [1:0].
  - The image processor consumes the same constants.
- One natural sub-module: `rgb565_to_rgb332`, a pure combinational pack honouring `SWAP_BYTES`.
- Everything else is flat: FSM, counters, phase, output registers.

## Test plan

- **Reset then one clean frame:** VSYNC pulse, 144 lines of 352 bytes each, then VSYNC.
  - Expect 25344 `W_EN` pulses, last at X = 175 / Y = 143.
  - Expect one `FRAME_DONE` and `LINE_ERR` = 0.
- **Packing:** bytes 0xF8, 0x00 → `PIXEL_OUT` 0xE0. Bytes 0x07, 0xE0 → 0x1C. Bytes 0x00, 0x1F → 0x03.
  - With `SWAP_BYTES` = 1 and order 0x1F, 0x00 → 0x03.
- **Oversize frame:** 200 px × 160 lines.
  - Writes only for X < 176 and Y < 144.
  - Expect no write with X ≥ 176, and `LINE_ERR` = 1.
- **Odd line:** 351 bytes on line 5.
  - Line 5 yields 175 writes, `LINE_ERR` = 1.
  - Line 6 starts at X = 0 with the correct byte pairing.
- **Reset mid-frame:** `RESET` at line 70.
  - No writes until the next VSYNC fall, then Y restarts at 0.
  - Data between reset and VSYNC is ignored.
- **Simultaneous VSYNC+HREF:** assert VSYNC while HREF = 1 at X = 100.
  - Expect no further writes, `FRAME_DONE` pulses once, state `VBLANK`.
